pipe_hazard_ctrl: RTL and testbench

// Hazard/sequencing controller for the 5-stage MIPS pipeline. Tracks the destination register, write
// and load flags of the instructions in EX, MEM and WB. From these it drives the pipeline-register

---
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and data-memory wait sequencing beside the decode unit of a 5-stage MIPS pipe.
// Build option: define HAZ_FORWARD_EN for EX operand forwarding (then only load-use stalls).
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter bit RF_BYPASS   = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_br_taken,
  input  logic              dmem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_adv,
  output logic              pc_sel_br,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dmem_req,
  output logic              mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              reg_write;
    logic              mem_read;
    logic              mem_acc;
  } stage_t;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  function automatic logic hz_match(input logic vld, input stage_t s, input logic idv,
                                    input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                    input logic use_rs, input logic use_rt);
    return idv && vld && s.reg_write && (s.dst != '0) &&
           ((use_rs && (rs == s.dst)) || (use_rt && (rt == s.dst)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

`ifdef HAZ_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input stage_t m, input stage_t w);
    if (m.reg_write && (m.dst != '0) && (m.dst == src))      return 2'b10;
    else if (w.reg_write && (w.dst != '0) && (w.dst == src)) return 2'b01;
    else                                                      return 2'b00;
  endfunction
`endif

  stage_t           stg_p0, stg_p1, stg_p2;   // EX, MEM, WB shadows
  logic             vld_p0, vld_p1, vld_p2;
  stage_t           id_stg;
  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_nxt;
  logic             hz_ex, hz_mem, hz_wb;
  logic             raw_stall;
  logic             br_take;

  assign id_stg = '{dst: id_dst, rs: id_rs, rt: id_rt, reg_write: id_reg_write,
                    mem_read: id_mem_read, mem_acc: id_mem_read | id_mem_write};

  assign hz_ex  = hz_match(vld_p0, stg_p0, id_valid, id_rs, id_rt, id_use_rs, id_use_rt);
  assign hz_mem = hz_match(vld_p1, stg_p1, id_valid, id_rs, id_rt, id_use_rs, id_use_rt);
  assign hz_wb  = hz_match(vld_p2, stg_p2, id_valid, id_rs, id_rt, id_use_rs, id_use_rt);

`ifdef HAZ_FORWARD_EN
  assign raw_stall = hz_ex && stg_p0.mem_read;
  assign fwd_a     = reset ? 2'b00 : fwd_sel(stg_p0.rs, stg_p1, stg_p2);
  assign fwd_b     = reset ? 2'b00 : fwd_sel(stg_p0.rt, stg_p1, stg_p2);
`else
  assign raw_stall = hz_ex || hz_mem || (!RF_BYPASS && hz_wb);
  assign fwd_a     = 2'b00;
  assign fwd_b     = 2'b00;
`endif

  // Some fields and match terms are only consumed in one build configuration.
  logic unused_bits;
  assign unused_bits = ^{stg_p0, stg_p1, stg_p2, hz_mem, hz_wb};

  assign dmem_req = vld_p1 && stg_p1.mem_acc && !reset;
  assign pipe_adv = !reset && !(dmem_req && !dmem_ack);
  assign br_take  = ex_br_taken && pipe_adv && vld_p0;

  // A frozen pipe keeps every enable low, so stall and branch wait for the next advance.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_sel_br   = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (br_take) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pc_sel_br   = 1'b1;
    end else if (raw_stall && pipe_adv) begin
      idex_bubble = 1'b1;
    end else begin
      pc_write    = pipe_adv;
      ifid_write  = pipe_adv;
    end
  end

  // ---- ID -> EX -> MEM -> WB shadow advance ----
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_p0 <= '0;
      stg_p1 <= '0;
      stg_p2 <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (pipe_adv) begin
      stg_p2 <= stg_p1;
      vld_p2 <= vld_p1;
      stg_p1 <= stg_p0;
      vld_p1 <= vld_p0;
      if (idex_bubble || !id_valid) begin
        stg_p0 <= '0;
        vld_p0 <= 1'b0;
      end else begin
        stg_p0 <= id_stg;
        vld_p0 <= 1'b1;
      end
    end
  end

  assign wcnt_nxt = sat_inc(wcnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dmem_req && !dmem_ack) begin
            state <= ST_WAIT;
            wcnt  <= '0;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state <= ST_RUN;
          end else begin
            wcnt <= wcnt_nxt;
            if (wcnt_nxt >= CNT_W'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dependent ALU pairs, load-use, branch vs stall,
// memory wait states, timeout and register-0 handling. Expectations follow HAZ_FORWARD_EN.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic       ex_br_taken, dmem_ack;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_adv, pc_sel_br;
  logic [1:0] fwd_a, fwd_b;
  logic       dmem_req, mem_timeout;

  int errs   = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .RF_BYPASS(1'b1), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_br_taken(ex_br_taken), .dmem_ack(dmem_ack), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_adv(pipe_adv), .pc_sel_br(pc_sel_br), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Packed order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_adv, pc_sel_br}
  task automatic ctl_chk(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_adv, pc_sel_br}, {26'd0, exp});
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    id_idle();
    ex_br_taken = 1'b0;
    dmem_ack    = 1'b0;
    repeat (3) tick();
  endtask

  localparam logic [5:0] C_RUN   = 6'b110010;
  localparam logic [5:0] C_STALL = 6'b000110;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b001100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ex_br_taken = 1'b0; dmem_ack = 1'b0;
    id_idle();
    repeat (2) tick();
    #1;
    ctl_chk("reset_ctl", C_RST);
    chk("reset_req", dmem_req, 1'b0);
    chk("reset_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("reset_tmo", mem_timeout, 1'b0);
    reset = 1'b0;
    #1;
    ctl_chk("idle_run", C_RUN);

    // add $3,$1,$2 ; sub $4,$3,$5
    tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); #1;
    ctl_chk("t1_add", C_RUN);
    tick(); id_set(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); #1;
`ifdef HAZ_FORWARD_EN
    ctl_chk("t1_no_stall", C_RUN);
    tick(); id_idle(); #1;
    chk("t1_fwd_a", fwd_a, 2'b10);
    chk("t1_fwd_b", fwd_b, 2'b00);
`else
    ctl_chk("t1_stall_ex", C_STALL);
    tick(); #1;
    ctl_chk("t1_stall_mem", C_STALL);
    tick(); #1;
    ctl_chk("t1_wb_bypass", C_RUN);
    tick(); id_idle(); #1;
    chk("t1_fwd_off", {fwd_a, fwd_b}, 4'b0000);
`endif
    drain();

    // lw $2,0($1) ; add $4,$2,$2
    tick(); id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); #1;
    ctl_chk("t2_lw", C_RUN);
    tick(); id_set(1, 5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0); #1;
    ctl_chk("t2_load_use", C_STALL);
    tick(); dmem_ack = 1'b1; #1;
    chk("t2_req", dmem_req, 1'b1);
`ifdef HAZ_FORWARD_EN
    ctl_chk("t2_ack0_adv", C_RUN);
    tick(); id_idle(); #1;
    chk("t2_req_gone", dmem_req, 1'b0);
    ctl_chk("t2_ack_ignored", C_RUN);
    chk("t2_fwd", {fwd_a, fwd_b}, 4'b0101);
`else
    ctl_chk("t2_stall_mem", C_STALL);
    tick(); #1;
    chk("t2_req_gone", dmem_req, 1'b0);
    ctl_chk("t2_ack_ignored", C_RUN);
    tick(); id_idle(); dmem_ack = 1'b0; #1;
    chk("t2_fwd_off", {fwd_a, fwd_b}, 4'b0000);
`endif
    drain();

    // add $7 ; beq $8,$9 ; or $10,$7 with branch taken in EX
    tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0); #1;
    tick(); id_set(1, 5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 0); #1;
    ctl_chk("t3_beq_id", C_RUN);
    tick(); id_set(1, 5'd7, 5'd0, 1, 0, 5'd10, 1, 0, 0); ex_br_taken = 1'b1; #1;
    ctl_chk("t3_branch_wins", C_BR);
    chk("t3_req", dmem_req, 1'b0);
    tick(); id_idle(); #1;
    ctl_chk("t3_br_needs_valid", C_RUN);
    drain();

    // sw in MEM, beq in EX, three wait states then ack
    tick(); id_set(1, 5'd6, 5'd5, 1, 1, 5'd0, 0, 0, 1); #1;
    tick(); id_set(1, 5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 0); #1;
    ctl_chk("t4_beq_id", C_RUN);
    tick(); id_idle(); ex_br_taken = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      ctl_chk($sformatf("t4_frozen%0d", i), C_FRZ);
      chk($sformatf("t4_req%0d", i), dmem_req, 1'b1);
      tick();
    end
    dmem_ack = 1'b1; #1;
    ctl_chk("t4_resume_branch", C_BR);
    tick(); dmem_ack = 1'b0; ex_br_taken = 1'b0; #1;
    ctl_chk("t4_after", C_RUN);
    chk("t4_no_tmo", mem_timeout, 1'b0);
    drain();

    // lw in MEM never acked: timeout after 16 wait cycles, sticky, cleared by reset
    tick(); id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); #1;
    tick(); id_idle(); #1;
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t5_adv%0d", i), pipe_adv, 1'b0);
      chk($sformatf("t5_tmo_low%0d", i), mem_timeout, 1'b0);
      tick();
    end
    #1;
    chk("t5_tmo_set", mem_timeout, 1'b1);
    chk("t5_still_wait", pipe_adv, 1'b0);
    tick(); #1;
    chk("t5_tmo_sticky", mem_timeout, 1'b1);
    reset = 1'b1; #1;
    ctl_chk("t5_reset_ctl", C_RST);
    chk("t5_reset_req", dmem_req, 1'b0);
    tick(); reset = 1'b0; #1;
    chk("t5_tmo_clear", mem_timeout, 1'b0);
    chk("t5_req_clear", dmem_req, 1'b0);
    ctl_chk("t5_run", C_RUN);
    dmem_ack = 1'b1; #1;
    ctl_chk("t5_stray_ack", C_RUN);
    drain();

    // writer of $0 followed by reader of $0
    tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); #1;
    tick(); id_set(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0); #1;
    ctl_chk("t6_r0_no_stall", C_RUN);
    tick(); id_idle(); #1;
    chk("t6_r0_no_fwd", {fwd_a, fwd_b}, 4'b0000);
    ctl_chk("t6_run", C_RUN);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
